// File: rtl/step_pkg.sv
// Shared definitions for the step-counter path: FSM encoding and default
// thresholds used by the window sequencer, the display and other step-path blocks.
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int STEP_THRESH_DEF = 32;
    localparam int WINDOW_SECS_DEF = 10;
    localparam int CNT_W           = 6;
    localparam int WIN_W           = 4;

endpackage

// File: rtl/pulse_sync_edge.sv
// Brings an asynchronous pulse into the clk domain through two flops and
// emits a one-clk strobe on each rising edge of the synchronised level.
module pulse_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: non-blocking assignments make the three flops shift in lockstep;
    // blocking ones would collapse the chain into a single stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pulse;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/step_window_sequencer.sv
// Runs one observation window: 1 s tick generation, per-second step counting
// and tallying of seconds that reach the step threshold.
module step_window_sequencer
    import step_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int STEP_THRESH = STEP_THRESH_DEF,
    parameter int WINDOW_SECS = WINDOW_SECS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pulse,
    output logic             sec_tick,
    output logic [CNT_W-1:0] pulses_this_sec,
    output logic [WIN_W-1:0] over_count,
    output logic [WIN_W-1:0] window_sec,
    output logic             busy,
    output logic             done
);

    localparam int               PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(STEP_THRESH);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STEP_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_MAX    = WIN_W'(WINDOW_SECS);
    localparam logic [WIN_W-1:0] WIN_PRE    = WIN_W'(WINDOW_SECS - 1);

    state_e             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_pulses;
    logic [WIN_W-1:0]   r_over;
    logic [WIN_W-1:0]   r_win;
    logic               r_busy;
    logic               r_done;
    logic               w_edge;
    logic               w_tick;

    pulse_sync_edge u_pulse_sync_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_pulse (pulse),
        .o_edge  (w_edge)
    );

    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_pulses <= '0;
            r_over   <= '0;
            r_win    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (stop) begin
            r_state  <= ST_IDLE;
            r_pulses <= '0;
            r_over   <= '0;
            r_win    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start && (r_state != ST_RUN)) begin
            r_state  <= ST_RUN;
            r_presc  <= '0;
            r_pulses <= '0;
            r_over   <= '0;
            r_win    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_tick) begin
                r_presc <= '0;
                r_win   <= r_win + 1'b1;
                if ((r_pulses >= THRESH) && (r_over != WIN_MAX)) begin
                    r_over <= r_over + 1'b1;
                end
                // The final second's count stays visible once the window is done.
                if (r_win == WIN_PRE) begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_pulses <= w_edge ? CNT_W'(1) : '0;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
                if (w_edge && (r_pulses != CNT_SAT)) begin
                    r_pulses <= r_pulses + 1'b1;
                end
            end
        end
    end

    assign sec_tick        = w_tick;
    assign pulses_this_sec = r_pulses;
    assign over_count      = r_over;
    assign window_sec      = r_win;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_step_window_sequencer.sv
// Randomised window-level bench: pulses are scheduled per second and the
// expected counters are derived by binning those pulses into seconds.
module tb_step_window_sequencer;
    import step_pkg::*;

    localparam int CLK_HZ = 100;
    localparam int THR    = 32;
    localparam int WIN    = 10;
    localparam int SAT    = THR + 1;
    localparam int SPAN   = WIN * CLK_HZ;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pulse = 1'b0;
    logic             sec_tick;
    logic [CNT_W-1:0] pulses_this_sec;
    logic [WIN_W-1:0] over_count;
    logic [WIN_W-1:0] window_sec;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_window_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .STEP_THRESH (THR),
        .WINDOW_SECS (WIN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .pulse           (pulse),
        .sec_tick        (sec_tick),
        .pulses_this_sec (pulses_this_sec),
        .over_count      (over_count),
        .window_sec      (window_sec),
        .busy            (busy),
        .done            (done)
    );

    function automatic int overs(input int ne[WIN], input int upto);
        int c = 0;
        for (int s = 0; s < upto; s++) if (ne[s] >= THR) c++;
        return (c > WIN) ? WIN : c;
    endfunction

    // Runs one window. Pulse raises are scheduled at even offsets; a raise
    // counted at offset r (in clk after the accepting edge) belongs to second r/CLK_HZ.
    task automatic run_window(input int n[WIN], input bit tick_edge, input int stop_at,
                              input bit hold_start, input string tag);
        bit sched[0:SPAN+3];
        int ne[WIN];
        int seen[WIN];
        bit used[50];
        int a, k, cnt, lo, j, exp_p, exp_w, exp_o;
        bit exp_t, exp_b, exp_d;
        for (int i = 0; i <= SPAN + 3; i++) sched[i] = 1'b0;
        for (int s = 0; s < WIN; s++) begin
            for (int i = 0; i < 50; i++) used[i] = 1'b0;
            lo  = (s == 0) ? 2 : 0;
            k   = (n[s] > 50 - lo) ? 50 - lo : n[s];
            cnt = 0;
            if (tick_edge && s == 1 && k > 0) begin
                used[0] = 1'b1;
                cnt = 1;
            end
            while (cnt < k) begin
                j = int'($urandom_range(49, lo));
                if (!used[j]) begin
                    used[j] = 1'b1;
                    cnt++;
                end
            end
            for (int i = 0; i < 50; i++) if (used[i]) sched[s * CLK_HZ + 2 * i] = 1'b1;
        end
        for (int s = 0; s < WIN; s++) begin
            ne[s] = 0;
            seen[s] = 0;
        end
        for (int r = 1; r < SPAN; r++) if (sched[r]) ne[r / CLK_HZ]++;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = hold_start;
        a = cyc;
        for (int d = 0; d <= SPAN; d++) begin
            if (d > 0) @(negedge clk);
            if (stop_at >= 0 && d == stop_at + 1) begin
                checks++;
                if ({sec_tick, pulses_this_sec, over_count, window_sec, busy, done} !== '0) begin
                    errors++;
                    $display("FAIL %s stop_clear got tick=%0b p=%0d o=%0d w=%0d b=%0b d=%0b exp all 0",
                             tag, sec_tick, pulses_this_sec, over_count, window_sec, busy, done);
                end
                stop = 1'b0;
                start = 1'b0;
                pulse = 1'b0;
                return;
            end
            if (d >= 1 && d < SPAN && sched[d]) seen[d / CLK_HZ]++;
            if (d < SPAN) begin
                exp_t = (d % CLK_HZ) == CLK_HZ - 1;
                exp_p = (seen[d / CLK_HZ] > SAT) ? SAT : seen[d / CLK_HZ];
                exp_w = d / CLK_HZ;
                exp_o = overs(ne, d / CLK_HZ);
                exp_b = 1'b1;
                exp_d = 1'b0;
            end else begin
                exp_t = 1'b0;
                exp_p = (seen[WIN-1] > SAT) ? SAT : seen[WIN-1];
                exp_w = WIN;
                exp_o = overs(ne, WIN);
                exp_b = 1'b0;
                exp_d = 1'b1;
            end
            checks++;
            if (sec_tick !== exp_t) begin
                errors++;
                $display("FAIL %s sec_tick d=%0d got %0b exp %0b", tag, d, sec_tick, exp_t);
            end
            checks++;
            if (pulses_this_sec !== CNT_W'(exp_p)) begin
                errors++;
                $display("FAIL %s pulses d=%0d got %0d exp %0d", tag, d, pulses_this_sec, exp_p);
            end
            checks++;
            if (window_sec !== WIN_W'(exp_w)) begin
                errors++;
                $display("FAIL %s window_sec d=%0d got %0d exp %0d", tag, d, window_sec, exp_w);
            end
            checks++;
            if (over_count !== WIN_W'(exp_o)) begin
                errors++;
                $display("FAIL %s over_count d=%0d got %0d exp %0d", tag, d, over_count, exp_o);
            end
            checks++;
            if ({busy, done} !== {exp_b, exp_d}) begin
                errors++;
                $display("FAIL %s busy_done d=%0d got %0b%0b exp %0b%0b", tag, d, busy, done, exp_b, exp_d);
            end
            pulse = sched[d + 3];
            stop  = (d == stop_at);
            start = hold_start && (d < SPAN - 10);
        end
        pulse = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sec_tick, pulses_this_sec, over_count, window_sec, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state got b=%0b d=%0b p=%0d exp all 0", busy, done, pulses_this_sec);
        end
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            pulse = ~pulse;
        end
        checks++;
        if ({busy, window_sec} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL pre_reset_run got busy=%0b win=%0d exp busy=1 win=1", busy, window_sec);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sec_tick, pulses_this_sec, over_count, window_sec, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_window got b=%0b p=%0d w=%0d exp all 0", busy, pulses_this_sec, window_sec);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulse = ~pulse;
        end
        pulse = 1'b0;
        checks++;
        if ({sec_tick, pulses_this_sec, over_count, window_sec, busy, done} !== '0) begin
            errors++;
            $display("FAIL idle_pulses got p=%0d b=%0b exp all 0", pulses_this_sec, busy);
        end
    endtask

    task automatic test_full_window();
        int n[WIN];
        for (int s = 0; s < WIN; s++) n[s] = 40;
        run_window(n, 1'b0, -1, 1'b0, "full40");
        checks++;
        if ({over_count, window_sec, done, busy} !== {4'd10, 4'd10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full40_result got o=%0d w=%0d d=%0b b=%0b exp o=10 w=10 d=1 b=0",
                     over_count, window_sec, done, busy);
        end
    endtask

    task automatic test_threshold();
        int n[WIN];
        for (int s = 0; s < WIN; s++) n[s] = (s % 2 == 0) ? 31 : 32;
        run_window(n, 1'b0, -1, 1'b1, "alt31_32");
        checks++;
        if (over_count !== 4'd5) begin
            errors++;
            $display("FAIL alt31_32_over got %0d exp 5", over_count);
        end
    endtask

    task automatic test_saturation();
        int n[WIN];
        n[0] = 50;
        n[1] = 5;
        for (int s = 2; s < WIN; s++) n[s] = int'($urandom_range(40, 0));
        run_window(n, 1'b1, -1, 1'b0, "saturate");
    endtask

    task automatic test_stop();
        int n[WIN];
        for (int s = 0; s < WIN; s++) n[s] = int'($urandom_range(40, 28));
        run_window(n, 1'b0, 320, 1'b0, "stop");
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({busy, done, window_sec} !== {1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL start_stop_same got b=%0b d=%0b w=%0d exp idle", busy, done, window_sec);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, sec_tick, window_sec} !== '0) begin
            errors++;
            $display("FAIL start_stop_stay got b=%0b t=%0b w=%0d exp idle", busy, sec_tick, window_sec);
        end
    endtask

    task automatic test_done_restart();
        int n[WIN];
        n = '{35, 10, 40, 32, 31, 33, 50, 0, 36, 34};
        run_window(n, 1'b0, -1, 1'b0, "over7");
        checks++;
        if ({over_count, done} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL over7_result got o=%0d d=%0b exp o=7 d=1", over_count, done);
        end
        for (int s = 0; s < WIN; s++) n[s] = int'($urandom_range(38, 26));
        run_window(n, 1'b0, -1, 1'b0, "restart");
    endtask

    task automatic test_back_to_back();
        int n[WIN];
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < WIN; s++) n[s] = int'($urandom_range(45, 20));
            run_window(n, r[0], -1, 1'b0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_threshold();
        test_saturation();
        test_stop();
        test_done_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
